// File: rtl/pbl_defs.sv
// Shared definitions for the naval-battle board: geometry, phase codes
// and the game controller state encoding.
package pbl_defs;

    localparam int N_LIN  = 7;
    localparam int N_COL  = 5;
    localparam int N_CELL = 35;
    localparam int IDX_W  = 6;

    localparam logic [1:0] PH_SETUP  = 2'b00;
    localparam logic [1:0] PH_ATTACK = 2'b01;
    localparam logic [1:0] PH_WIN    = 2'b10;
    localparam logic [1:0] PH_LOSE   = 2'b11;

    typedef enum logic [2:0] {
        ST_SETUP  = 3'd0,
        ST_ATTACK = 3'd1,
        ST_CHECK  = 3'd2,
        ST_WIN    = 3'd3,
        ST_LOSE   = 3'd4
    } state_t;

endpackage

// File: rtl/modulo_controle_jogo_if.sv
// Board-side bundle of the game controller: button/tick inputs, coordinates,
// matrix contents, and the strobes, events and counters it produces.
// master = board/stimulus side, slave = controller side.
interface modulo_controle_jogo_if
    import pbl_defs::*;
#(
    parameter int SHOT_W = 6
);

    logic                tick;
    logic                btn_fire;
    logic                btn_start;
    logic [2:0]          coord_lin;
    logic [2:0]          coord_col;
    logic [N_CELL-1:0]   pos_map;
    logic [N_CELL-1:0]   atk_map;

    logic [1:0]          phase;
    logic                po_we;
    logic                atk_we;
    logic [IDX_W-1:0]    atk_idx;
    logic                atk_clr;
    logic                hit;
    logic                miss;
    logic                ev_repeat;
    logic                ev_err;
    logic [SHOT_W-1:0]   shots_left;
    logic [5:0]          hits;
    logic [5:0]          targets;

    modport master (
        output tick, btn_fire, btn_start, coord_lin, coord_col, pos_map, atk_map,
        input  phase, po_we, atk_we, atk_idx, atk_clr, hit, miss,
               ev_repeat, ev_err, shots_left, hits, targets
    );

    modport slave (
        input  tick, btn_fire, btn_start, coord_lin, coord_col, pos_map, atk_map,
        output phase, po_we, atk_we, atk_idx, atk_clr, hit, miss,
               ev_repeat, ev_err, shots_left, hits, targets
    );

endinterface

// File: rtl/modulo_debounce.sv
// Button debouncer: 2-FF synchroniser, tick-paced stability counter and a
// one-cycle pulse on each rising edge of the debounced level.
module modulo_debounce #(
    parameter int TICKS = 20
) (
    input  logic clk,
    input  logic clr,
    input  logic tick,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(TICKS + 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Synchronise the raw button and flip the level after TICKS stable ticks
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= raw;
            sync_b  <= sync_a;
            level_d <= level;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CW'(TICKS - 1)) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/modulo_controle_jogo.sv
// Game-phase controller for the naval-battle board: placement, attack and
// end-of-game sequencing, shot checking against the position map, and the
// shot/hit counters. Optional macro SCORE_BCD_EN presents shots_left and
// hits as two BCD digits {tens[1:0], units[3:0]} (MAX_SHOTS <= 39).
module modulo_controle_jogo
    import pbl_defs::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
    parameter int MAX_SHOTS      = 15,
    parameter int SHOT_W         = 6
) (
    input  logic                  clk,
    input  logic                  clr,
    modulo_controle_jogo_if.slave bus
);

    localparam logic [SHOT_W-1:0] SHOT_MAX  = SHOT_W'(MAX_SHOTS);
    localparam logic [IDX_W-1:0]  LAST_CELL = IDX_W'(N_CELL - 1);

    logic              fire_p;
    logic              start_p;

    state_t            state;
    logic [1:0]        phase_r;
    logic              po_we_r;
    logic              atk_we_r;
    logic [IDX_W-1:0]  atk_idx_r;
    logic              atk_clr_r;
    logic              hit_r;
    logic              miss_r;
    logic              ev_repeat_r;
    logic              ev_err_r;
    logic [SHOT_W-1:0] shots_cnt;
    logic [5:0]        hits_cnt;
    logic [5:0]        targets_r;

    logic [5:0]        pop;
    logic [IDX_W-1:0]  cell_idx;
    logic              coord_ok;
    logic              atk_bit;
    logic              shot_hit;
    logic [5:0]        hits_next;
    logic [SHOT_W-1:0] shots_next;

    modulo_debounce #(.TICKS(DEBOUNCE_TICKS)) u_deb_fire (
        .clk   (clk),
        .clr   (clr),
        .tick  (bus.tick),
        .raw   (bus.btn_fire),
        .press (fire_p)
    );

    modulo_debounce #(.TICKS(DEBOUNCE_TICKS)) u_deb_start (
        .clk   (clk),
        .clr   (clr),
        .tick  (bus.tick),
        .raw   (bus.btn_start),
        .press (start_p)
    );

    // Number of occupied cells on the position map
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CELL; i++) begin
            pop = pop + 6'(bus.pos_map[i]);
        end
    end

    // Target cell decode and lookup of the already-attacked bit
    always_comb begin
        coord_ok = (bus.coord_lin <= 3'(N_LIN - 1)) && (bus.coord_col <= 3'(N_COL - 1));
        cell_idx = {3'b000, bus.coord_lin} * IDX_W'(N_COL) + {3'b000, bus.coord_col};
        atk_bit  = 1'b0;
        if (coord_ok) begin
            atk_bit = bus.atk_map[LAST_CELL - cell_idx];
        end
    end

    // Outcome of the shot being resolved in CHECK, with saturating counters
    always_comb begin
        shot_hit   = bus.pos_map[LAST_CELL - atk_idx_r];
        hits_next  = hits_cnt;
        shots_next = shots_cnt;
        if (shot_hit && (hits_cnt != 6'h3f)) begin
            hits_next = hits_cnt + 6'd1;
        end
        if (shots_cnt != '0) begin
            shots_next = shots_cnt - 1'b1;
        end
    end

    // Game sequencing FSM with registered strobes, events and counters
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= ST_SETUP;
            phase_r     <= PH_SETUP;
            po_we_r     <= 1'b0;
            atk_we_r    <= 1'b0;
            atk_idx_r   <= '0;
            atk_clr_r   <= 1'b0;
            hit_r       <= 1'b0;
            miss_r      <= 1'b0;
            ev_repeat_r <= 1'b0;
            ev_err_r    <= 1'b0;
            shots_cnt   <= SHOT_MAX;
            hits_cnt    <= '0;
            targets_r   <= '0;
        end else begin
            po_we_r     <= 1'b0;
            atk_we_r    <= 1'b0;
            atk_clr_r   <= 1'b0;
            ev_repeat_r <= 1'b0;
            ev_err_r    <= 1'b0;
            unique case (state)
                ST_SETUP: begin
                    if (start_p) begin
                        if (pop == '0) begin
                            ev_err_r <= 1'b1;
                        end else begin
                            targets_r <= pop;
                            hits_cnt  <= '0;
                            shots_cnt <= SHOT_MAX;
                            hit_r     <= 1'b0;
                            miss_r    <= 1'b0;
                            atk_clr_r <= 1'b1;
                            phase_r   <= PH_ATTACK;
                            state     <= ST_ATTACK;
                        end
                    end else if (fire_p) begin
                        po_we_r <= 1'b1;
                    end
                end
                ST_ATTACK: begin
                    if (start_p) begin
                        atk_clr_r <= 1'b1;
                        phase_r   <= PH_SETUP;
                        state     <= ST_SETUP;
                    end else if (fire_p) begin
                        if (!coord_ok) begin
                            ev_err_r <= 1'b1;
                        end else if (atk_bit) begin
                            ev_repeat_r <= 1'b1;
                        end else begin
                            atk_idx_r <= cell_idx;
                            atk_we_r  <= 1'b1;
                            state     <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    shots_cnt <= shots_next;
                    hits_cnt  <= hits_next;
                    hit_r     <= shot_hit;
                    miss_r    <= ~shot_hit;
                    if (hits_next == targets_r) begin
                        phase_r <= PH_WIN;
                        state   <= ST_WIN;
                    end else if (shots_next == '0) begin
                        phase_r <= PH_LOSE;
                        state   <= ST_LOSE;
                    end else begin
                        state <= ST_ATTACK;
                    end
                end
                ST_WIN, ST_LOSE: begin
                    if (start_p) begin
                        atk_clr_r <= 1'b1;
                        shots_cnt <= SHOT_MAX;
                        hits_cnt  <= '0;
                        phase_r   <= PH_SETUP;
                        state     <= ST_SETUP;
                    end
                end
                default: begin
                    phase_r <= PH_SETUP;
                    state   <= ST_SETUP;
                end
            endcase
        end
    end

`ifdef SCORE_BCD_EN
    function automatic logic [5:0] to_bcd(input logic [5:0] v);
        return {2'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    assign bus.shots_left = SHOT_W'(to_bcd(6'(shots_cnt)));
    assign bus.hits       = to_bcd(hits_cnt);
`else
    assign bus.shots_left = shots_cnt;
    assign bus.hits       = hits_cnt;
`endif

    assign bus.phase     = phase_r;
    assign bus.po_we     = po_we_r;
    assign bus.atk_we    = atk_we_r;
    assign bus.atk_idx   = atk_idx_r;
    assign bus.atk_clr   = atk_clr_r;
    assign bus.hit       = hit_r;
    assign bus.miss      = miss_r;
    assign bus.ev_repeat = ev_repeat_r;
    assign bus.ev_err    = ev_err_r;
    assign bus.targets   = targets_r;

endmodule

// File: doc/modulo_controle_jogo.md
Name: modulo_controle_jogo

Overview:
Game-phase controller for the naval-battle board. It sequences ship placement, attack and end-of-game, and owns the write strobes into the position and attack matrix registers. It checks every shot against the 5x7 position map and drives the 2-bit phase code used by the display multiplexers and the matrix selector. It also keeps the shot and hit counters.

Parameters:
DEBOUNCE_TICKS, 20, consecutive stable `tick` samples needed to accept a button level change
MAX_SHOTS, 15, shots available per game (1..63)
SHOT_W, 6, width of the shot counter

Ports:
clk  in  1  system clock
clr  in  1  asynchronous active-high reset
tick  in  1  one-cycle enable from the frequency divider (~1 ms)
btn_fire  in  1  raw fire/place button, active-high
btn_start  in  1  raw start/abort button, active-high
coord_lin  in  3  target line, 0..6
coord_col  in  3  target column, 0..4
pos_map  in  35  position matrix contents; bit 34-(lin*5+col)
atk_map  in  35  attack matrix contents, same indexing
phase  out  2  00 SETUP, 01 ATTACK, 10 WIN, 11 LOSE
po_we  out  1  one-cycle load strobe for the position register
atk_we  out  1  one-cycle write strobe for the attack register
atk_idx  out  6  cell index lin*5+col, valid while atk_we=1
atk_clr  out  1  one-cycle clear of the attack register
hit  out  1  level: last shot hit
miss  out  1  level: last shot missed
ev_repeat  out  1  one-cycle pulse: cell already attacked
ev_err  out  1  one-cycle pulse: invalid coordinate or empty board
shots_left  out  SHOT_W  remaining shots
hits  out  6  hits scored
targets  out  6  occupied cells latched at start

Behaviour:
- Reset (async, clr=1): state SETUP; phase=00; all strobes and pulses 0; hit=miss=0; shots_left=MAX_SHOTS; hits=0; targets=0; debouncers cleared. Reset asserted mid-game aborts immediately.
- Debounce, per button:
  - 2-FF synchroniser.
  - Counter advances only on tick while the synchronised level differs from the debounced level; cleared when they match.
  - At DEBOUNCE_TICKS the debounced level flips.
  - A rising edge of the debounced level produces a one-cycle press pulse (fire_p, start_p).
- Priority: start_p beats fire_p in the same cycle; fire_p is dropped.
- States: SETUP, ATTACK, CHECK, WIN, LOSE. CHECK reports phase 01.
- SETUP:
  - fire_p -> po_we=1 for one cycle.
  - start_p with popcount(pos_map)=0 -> ev_err, stay in SETUP.
  - start_p otherwise -> targets=popcount, hits=0, shots_left=MAX_SHOTS, hit=miss=0, atk_clr=1, go to ATTACK.
- ATTACK:
  - fire_p with coord_lin>6 or coord_col>4 -> ev_err, stay.
  - fire_p on a cell whose atk_map bit is set -> ev_repeat, stay; no shot consumed.
  - fire_p otherwise -> latch index, go to CHECK.
  - start_p -> abort: atk_clr, go to SETUP.
- CHECK (exactly one cycle):
  - atk_we=1 with atk_idx.
  - shots_left decrements.
  - If the pos_map bit is set: hits increments, hit=1, miss=0. Otherwise miss=1, hit=0.
  - Next state, using the updated values: hits==targets -> WIN; else shots_left==0 -> LOSE; else ATTACK. A hit on the last shot is a WIN.
- WIN/LOSE: counters and hit/miss frozen; fire ignored; start_p -> atk_clr, go to SETUP, shots_left=MAX_SHOTS, hits=0.
- Latency: fire_p in cycle N -> atk_we in N+1 -> counters and phase updated at N+2.
- Counters are saturating; they never wrap below 0 or above their width.
- po_we, atk_we and atk_clr are mutually exclusive in every cycle.

Optional Feature:
SCORE_BCD_EN
- Defined: shots_left and hits are presented as two BCD digits each ({tens[1:0], units[3:0]}, max 39; MAX_SHOTS limited to 39), ready for the 7-segment decoder.
- Undefined: plain binary, as specified above.

Decomposition:
- Shared package/include pbl_defs: N_LIN=7, N_COL=5, N_CELL=35, phase codes PH_SETUP/PH_ATTACK/PH_WIN/PH_LOSE, state encoding.
- One sub-module, modulo_debounce (sync + tick counter + edge pulse), instantiated twice.
- Popcount and BCD conversion stay inline.

Test Plan:
- clr pulse mid-ATTACK (shots_left=7) -> phase=00, shots_left=15, hits=0 at once, with no clk edge needed.
- btn_fire bounce, 3 toggles each shorter than 20 ticks, then held 25 ticks in SETUP -> exactly one po_we pulse.
- pos_map=0, start press -> ev_err once, phase stays 00; pos_map with 3 bits set, start -> targets=3, atk_clr pulse, phase=01.
- ATTACK at lin=2, col=3 on an occupied cell -> atk_we with atk_idx=13 one cycle after fire_p; hits=1, hit=1, shots_left=14. Firing again at the same cell -> ev_repeat, shots_left stays 14.
- coord_col=5 fire -> ev_err, no atk_we; simultaneous start+fire in ATTACK -> abort to SETUP, no atk_we.
- MAX_SHOTS=2, targets=1, miss then hit -> WIN (phase=10); variant miss, miss -> LOSE (phase=11); fire in WIN/LOSE ignored.
